alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Issue/control stage that sits directly upstream of the 16-bit ALU (4-bit operation, in1, in2 -> rd, carry, eq, neg).
- Accepts 16-bit instructions over a valid/ready handshake and holds an 8x16 register file.
- Sequences each instruction through read, execute and writeback, driving the ALU operands and consuming its result and flags.
- Owns the architectural flag register and a sticky illegal-opcode indicator.

Parameters:
- NREGS, 8, number of general registers; index width is 3 and is fixed for this release.
- DW, 16, datapath width; must match the ALU width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction present on instr
- instr  input  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored
- instr_ready  output  1  block can accept an instruction this cycle
- alu_op  output  4  operation to the ALU
- alu_in1  output  16  ALU operand 1
- alu_in2  output  16  ALU operand 2
- alu_rd  input  16  ALU result
- alu_carry  input  1  ALU carry
- alu_eq  input  1  ALU equal
- alu_neg  input  1  ALU negative
- wb_valid  output  1  one-cycle pulse when a register is written
- wb_addr  output  3  destination register of the write
- wb_data  output  16  data written
- flag_carry  output  1  architectural carry flag
- flag_eq  output  1  architectural equal flag
- flag_neg  output  1  architectural negative flag
- illegal  output  1  sticky; set by opcode 1110 or 1111
- dbg_addr  input  3  debug read index
- dbg_data  output  16  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all registers, alu_op/in1/in2, wb_*, flags and illegal = 0.
  - instr_ready is 1 immediately after reset releases.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE, unconditional except at IDLE.
- instr_ready = (state==IDLE). Accept when instr_valid && instr_ready; the instruction is latched on that edge. No accept in any other state.
- READ: latch opcode, rd, regfile[rs1] and regfile[rs2] into operand registers.
- EXEC: alu_op, alu_in1 and alu_in2 are driven from registers and stay stable for the whole cycle. alu_rd, carry, eq and neg are captured at the end of EXEC.
- WB, for ALU opcodes 0001..1100:
  - regfile[rd] <= captured result.
  - wb_valid=1 with wb_addr=rd and wb_data=result.
  - flags <= captured carry/eq/neg.
- WB, for opcode 1101 (LDI):
  - regfile[rd] <= zero-extended {instr[8:3]}; wb_valid=1.
  - Flags unchanged; alu_op driven 0000 during EXEC.
- WB, for opcode 0000 (NOP): no write, wb_valid=0, flags unchanged.
- WB, for opcodes 1110/1111: no write, flags unchanged; illegal <= 1, held until reset.
- Every instruction occupies 4 cycles from accept edge to the next instr_ready. Result latency is 3 cycles after accept (wb_valid in the WB cycle; regfile updated at the end of WB).
- r0 is hardwired 0: writes to rd=0 are discarded, but wb_valid still pulses with wb_addr=0 and the would-be data. Reads of r0 return 0.
- Same register as source and destination: READ uses the pre-instruction value.
- Back-to-back dependency: a following instruction's READ happens after the prior WB, so it always sees the new value. No bypass is required.
- wb_valid is registered and lasts exactly one cycle.
- wb_addr/wb_data hold their last values when wb_valid=0.
- alu_* outputs hold their last values outside EXEC.
- dbg_data reflects a write on the cycle after the WB edge.
- rst asserted mid-instruction: the instruction is abandoned, no partial writeback, all state returns to reset values.
- instr_valid held high while not ready: nothing is accepted; the instruction is taken on the first IDLE cycle.

Test Plan:
- Bench ALU model (0001 = add, eq = (in1==in2), neg = rd[15], carry = bit 16).
- Reset, then LDI r1=24, LDI r2=26, ADD(0001) r3=r1,r2 -> wb_valid pulses for r1, r2, r3; wb_data=50 on r3; dbg_data(r3)=50; flags carry=0, eq=0, neg=0.
- Second ADD with r2 loaded 63, then r1=r1+r1 repeatedly to 0x8000+0x8000 -> result 0, carry=1; alu_in1/alu_in2=0x8000 during EXEC.
- Hold instr_valid=1 continuously with 3 queued instructions -> instr_ready high exactly 1 of every 4 cycles; each wb_valid 3 cycles after its accept.
- Opcode 1111 to r4 -> illegal=1 and stays 1; r4 unchanged; next valid ADD still executes; illegal cleared only by rst.
- LDI r0=5 then dbg_addr=0 -> wb_valid pulse with wb_addr=0, dbg_data=0.
- Assert rst during EXEC of ADD r5 -> r5 stays 0, no wb_valid, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if : instruction handshake, ALU operand/result bus and
//                     writeback bus of the ALU issue/control stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_issue_ctrl_if #(
   parameter int DW = 16
);
   logic          instr_valid;
   logic [15:0]   instr;
   logic          instr_ready;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_in1;
   logic [DW-1:0] alu_in2;
   logic [DW-1:0] alu_rd;
   logic          alu_carry;
   logic          alu_eq;
   logic          alu_neg;
   logic          wb_valid;
   logic [2:0]    wb_addr;
   logic [DW-1:0] wb_data;

   // slave: the issue stage itself; master: instruction source + ALU + observer
   modport slave (
      input  instr_valid, instr, alu_rd, alu_carry, alu_eq, alu_neg,
      output instr_ready, alu_op, alu_in1, alu_in2, wb_valid, wb_addr, wb_data
   );
   modport master (
      output instr_valid, instr, alu_rd, alu_carry, alu_eq, alu_neg,
      input  instr_ready, alu_op, alu_in1, alu_in2, wb_valid, wb_addr, wb_data
   );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl : 4-cycle IDLE/READ/EXEC/WB issue stage with 8x16 regfile,
//                  architectural flags and sticky illegal-opcode indicator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl #(
   parameter int NREGS = 8,
   parameter int DW    = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   alu_issue_ctrl_if.slave    bus,
   output logic               flag_carry,
   output logic               flag_eq,
   output logic               flag_neg,
   output logic               illegal,
   input  wire logic [2:0]    dbg_addr,
   output logic [DW-1:0]      dbg_data
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'hD;
   localparam logic [3:0] OP_MAX = 4'hC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t        state;
   logic          ready;
   logic [15:0]   ir;
   logic [3:0]    op;
   logic [2:0]    rd;
   logic [3:0]    alu_op;
   logic [DW-1:0] alu_in1;
   logic [DW-1:0] alu_in2;
   logic          cap_carry;
   logic          cap_eq;
   logic          cap_neg;
   logic          wb_valid;
   logic [2:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic [DW-1:0] rf [NREGS];
   logic          op_is_alu;
   logic          op_is_illegal;
   logic          unused_bits;

   assign op_is_alu     = (op != OP_NOP) && (op <= OP_MAX);
   assign op_is_illegal = (op[3:1] == 3'b111);
   assign unused_bits   = ^ir[2:0];

   assign bus.instr_ready = ready;
   assign bus.alu_op      = alu_op;
   assign bus.alu_in1     = alu_in1;
   assign bus.alu_in2     = alu_in2;
   assign bus.wb_valid    = wb_valid;
   assign bus.wb_addr     = wb_addr;
   assign bus.wb_data     = wb_data;
   assign dbg_data        = rf[dbg_addr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ready      <= 1'b1;
         ir         <= '0;
         op         <= '0;
         rd         <= '0;
         alu_op     <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         cap_carry  <= 1'b0;
         cap_eq     <= 1'b0;
         cap_neg    <= 1'b0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         flag_carry <= 1'b0;
         flag_eq    <= 1'b0;
         flag_neg   <= 1'b0;
         illegal    <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            rf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.instr_valid && ready) begin
                  ir    <= bus.instr;
                  ready <= 1'b0;
                  state <= READ;
               end
            end
            READ: begin
               // Operands are sampled here so a same-register source sees the old value
               op      <= ir[15:12];
               rd      <= ir[11:9];
               alu_op  <= (ir[15:12] == OP_LDI) ? OP_NOP : ir[15:12];
               alu_in1 <= rf[ir[8:6]];
               alu_in2 <= rf[ir[5:3]];
               state   <= EXEC;
            end
            EXEC: begin
               cap_carry <= bus.alu_carry;
               cap_eq    <= bus.alu_eq;
               cap_neg   <= bus.alu_neg;
               if (op == OP_LDI) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= rd;
                  wb_data  <= {{(DW-6){1'b0}}, ir[8:3]};
               end else if (op_is_alu) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= rd;
                  wb_data  <= bus.alu_rd;
               end
               state <= WB;
            end
            WB: begin
               // r0 stays zero; the pulse is still reported on the writeback bus
               if (wb_valid && (rd != 3'd0)) begin
                  rf[rd] <= wb_data;
               end
               if (op_is_alu) begin
                  flag_carry <= cap_carry;
                  flag_eq    <= cap_eq;
                  flag_neg   <= cap_neg;
               end
               if (op_is_illegal) begin
                  illegal <= 1'b1;
               end
               wb_valid <= 1'b0;
               ready    <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl : directed bench with behavioural ALU and a writeback
//                     scoreboard for alu_issue_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic        flag_carry, flag_eq, flag_neg, illegal;

   alu_issue_ctrl_if #(.DW(16)) bus ();

   alu_issue_ctrl #(.NREGS(8), .DW(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .flag_carry (flag_carry),
      .flag_eq    (flag_eq),
      .flag_neg   (flag_neg),
      .illegal    (illegal),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [18:0] alu_model(input logic [3:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
      logic [16:0] r;
      case (op)
         4'h1:    r = {1'b0, a} + {1'b0, b};
         4'h2:    r = {1'b0, a} - {1'b0, b};
         default: r = {1'b0, a & b};
      endcase
      return {r[16], (a == b), r[15], r[15:0]};
   endfunction

   assign {bus.alu_carry, bus.alu_eq, bus.alu_neg, bus.alu_rd} =
      alu_model(bus.alu_op, bus.alu_in1, bus.alu_in2);

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
      int          cyc;
   } wb_t;

   wb_t         q[$];
   wb_t         mon_e;
   logic [15:0] m_rf [8];
   logic        m_c, m_e, m_n, m_ill;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          last_acc = 0;
   int          prev_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] alu_ins(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 3'b000};
   endfunction

   function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [5:0] imm);
      return {4'hD, rd, imm, 3'b000};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      m_c = 1'b0; m_e = 1'b0; m_n = 1'b0; m_ill = 1'b0;
   endtask

   // Presents ins, waits for acceptance and updates the reference model; leaves instr_valid high.
   task automatic send(input logic [15:0] ins);
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [18:0] r;
      logic [15:0] val;
      int          n;
      op = ins[15:12];
      rd = ins[11:9];
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      n = 0;
      while (bus.instr_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (bus.instr_ready !== 1'b1) chk("accept_timeout", {31'b0, bus.instr_ready}, 32'd1);
      last_acc = cyc;
      if (op == 4'hD) begin
         val = {10'b0, ins[8:3]};
         q.push_back('{rd, val, cyc + 3});
         if (rd != 3'd0) m_rf[rd] = val;
      end else if (op != 4'h0 && op <= 4'hC) begin
         r = alu_model(op, m_rf[ins[8:6]], m_rf[ins[5:3]]);
         q.push_back('{rd, r[15:0], cyc + 3});
         {m_c, m_e, m_n} = r[18:16];
         if (rd != 3'd0) m_rf[rd] = r[15:0];
      end else if (op[3:1] == 3'b111) begin
         m_ill = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.instr_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (bus.instr_ready !== 1'b1) chk("idle_timeout", {31'b0, bus.instr_ready}, 32'd1);
   endtask

   task automatic issue(input logic [15:0] ins);
      send(ins);
      bus.instr_valid = 1'b0;
      wait_idle();
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] idx);
      dbg_addr = idx;
      #1;
      chk(tag, {16'b0, dbg_data}, {16'b0, m_rf[idx]});
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, "_carry"}, {31'b0, flag_carry}, {31'b0, m_c});
      chk({tag, "_eq"},    {31'b0, flag_eq},    {31'b0, m_e});
      chk({tag, "_neg"},   {31'b0, flag_neg},   {31'b0, m_n});
      chk({tag, "_illegal"}, {31'b0, illegal},  {31'b0, m_ill});
   endtask

   always @(negedge clk) begin
      if (!rst && bus.wb_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("wb_unexpected", {31'b0, bus.wb_valid}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("wb_addr",  {29'b0, bus.wb_addr}, {29'b0, mon_e.addr});
            chk("wb_data",  {16'b0, bus.wb_data}, {16'b0, mon_e.data});
            chk("wb_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      model_reset();
      bus.instr_valid = 1'b0;
      bus.instr       = 16'h0;
      dbg_addr        = 3'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready",   {31'b0, bus.instr_ready}, 32'd1);
      chk("rst_wbvalid", {31'b0, bus.wb_valid},    32'd0);
      chk("rst_aluop",   {28'b0, bus.alu_op},      32'd0);
      chk("rst_aluin1",  {16'b0, bus.alu_in1},     32'd0);
      chk("rst_wbdata",  {16'b0, bus.wb_data},     32'd0);
      chk_flags("rst");

      // Basic LDI/ADD
      issue(ldi(3'd1, 6'd24));
      issue(ldi(3'd2, 6'd26));
      issue(alu_ins(4'h1, 3'd3, 3'd1, 3'd2));
      chk_reg("r3_sum", 3'd3);
      chk("r3_is_50", {16'b0, dbg_data}, 32'd50);
      chk_flags("add1");

      // Second add, then doubling r1 up to 0x8000 + 0x8000
      issue(ldi(3'd2, 6'd63));
      issue(alu_ins(4'h1, 3'd3, 3'd1, 3'd2));
      chk_reg("r3_sum2", 3'd3);
      issue(ldi(3'd1, 6'd32));
      for (int i = 0; i < 10; i++) issue(alu_ins(4'h1, 3'd1, 3'd1, 3'd1));
      chk_reg("r1_8000", 3'd1);
      send(alu_ins(4'h1, 3'd1, 3'd1, 3'd1));
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("exec_aluop",  {28'b0, bus.alu_op},  32'd1);
      chk("exec_aluin1", {16'b0, bus.alu_in1}, 32'h8000);
      chk("exec_aluin2", {16'b0, bus.alu_in2}, 32'h8000);
      wait_idle();
      chk_reg("r1_wrap", 3'd1);
      chk_flags("wrap");
      chk("wrap_carry_set", {31'b0, flag_carry}, 32'd1);

      // Streaming with instr_valid held high
      send(ldi(3'd6, 6'd5));
      prev_acc = last_acc;
      send(alu_ins(4'h1, 3'd7, 3'd6, 3'd6));
      chk("stream_gap1", last_acc - prev_acc, 32'd4);
      prev_acc = last_acc;
      send(alu_ins(4'h1, 3'd7, 3'd7, 3'd6));
      chk("stream_gap2", last_acc - prev_acc, 32'd4);
      bus.instr_valid = 1'b0;
      wait_idle();
      chk_reg("r7_stream", 3'd7);

      // Illegal opcodes
      issue(ldi(3'd4, 6'd9));
      issue(alu_ins(4'hF, 3'd4, 3'd1, 3'd2));
      chk_reg("r4_kept", 3'd4);
      chk_flags("ill");
      issue(alu_ins(4'h1, 3'd5, 3'd6, 3'd4));
      chk_reg("r5_after_ill", 3'd5);
      issue(alu_ins(4'hE, 3'd5, 3'd6, 3'd6));
      chk_reg("r5_after_ill2", 3'd5);
      chk_flags("ill2");

      // r0 writes discarded
      issue(ldi(3'd0, 6'd5));
      chk_reg("r0_zero", 3'd0);

      // Reset during EXEC
      issue(ldi(3'd5, 6'd0));
      send(alu_ins(4'h1, 3'd5, 3'd6, 3'd6));
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ready", {31'b0, bus.instr_ready}, 32'd1);
      chk_flags("midrst");
      repeat (6) @(negedge clk);
      chk_reg("r5_abandoned", 3'd5);
      issue(ldi(3'd5, 6'd3));
      chk_reg("r5_post_rst", 3'd5);

      repeat (2) @(negedge clk);
      chk("sb_empty", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
